vga_sync_generator: RTL and testbench

Downstream stage of the 25 MHz horizontal pixel counter. Consumes the horizontal count and its end-of-line enable pulse. Maintains the vertical line counter with a vertical-region FSM. Produces registered 640x480@60 VGA timing: hsync, vsync, video_on, pixel coordinates and frame/line markers for the pong renderer.

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_vertical_counter.sv | 48 ++++
 rtl/vga_sync_generator.sv | 77 +++++++
 tb/tb_vga_sync_generator.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants and the vertical-region state type shared by the
// sync generator and its line counter.
package vga_timing_pkg;

  localparam logic [15:0] H_ACTIVE = 16'd640;
  localparam logic [15:0] H_FP     = 16'd16;
  localparam logic [15:0] H_SYNC   = 16'd96;
  localparam logic [15:0] H_BP     = 16'd48;
  localparam logic [15:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam logic [15:0] V_ACTIVE = 16'd480;
  localparam logic [15:0] V_FP     = 16'd10;
  localparam logic [15:0] V_SYNC   = 16'd2;
  localparam logic [15:0] V_BP     = 16'd33;
  localparam logic [15:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_SYNC_START = H_ACTIVE + H_FP;
  localparam logic [15:0] H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC - 16'd1;

  // First line of each vertical region.
  localparam logic [15:0] V_FP_START   = V_ACTIVE;
  localparam logic [15:0] V_SYNC_START = V_ACTIVE + V_FP;
  localparam logic [15:0] V_BP_START   = V_ACTIVE + V_FP + V_SYNC;
  localparam logic [15:0] V_LAST       = V_TOTAL - 16'd1;

  typedef enum logic [1:0] {
    StVAct,
    StVFp,
    StVSync,
    StVBp
  } v_state_e;

endpackage

// File: rtl/vga_vertical_counter.sv
// Vertical line counter plus vertical-region FSM; both step only on the new-line enable.
// Exposes current and next values so the top can act on the effective line without lag.
module vga_vertical_counter
  import vga_timing_pkg::*;
(
  input  logic        clk_25MHz,
  input  logic        rst_n,
  input  logic        enable_V_Counter,
  output logic [15:0] v,
  output logic [15:0] v_next,
  output v_state_e    state,
  output v_state_e    state_next
);

  logic [15:0] v_q;
  v_state_e    state_q;

  assign v     = v_q;
  assign state = state_q;

  always_comb begin
    v_next = (v_q == V_LAST) ? 16'd0 : v_q + 16'd1;
  end

  // Region transitions are keyed on the line being entered, not the one being left.
  always_comb begin
    state_next = state_q;
    if (enable_V_Counter) begin
      unique case (state_q)
        StVAct:  if (v_next == V_FP_START)   state_next = StVFp;
        StVFp:   if (v_next == V_SYNC_START) state_next = StVSync;
        StVSync: if (v_next == V_BP_START)   state_next = StVBp;
        StVBp:   if (v_next == 16'd0)        state_next = StVAct;
      endcase
    end
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= 16'd0;
      state_q <= StVAct;
    end else begin
      if (enable_V_Counter) v_q <= v_next;
      state_q <= state_next;
    end
  end

endmodule

// File: rtl/vga_sync_generator.sv
// Registered 640x480@60 sync, blanking and pixel coordinates from the upstream horizontal
// count; every output reflects the inputs of the previous clock.
module vga_sync_generator
  import vga_timing_pkg::*;
#(
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk_25MHz,
  input  logic        rst_n,
  input  logic [15:0] H_Count_Value,
  input  logic        enable_V_Counter,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [15:0] V_Count_Value,
  output logic        line_start,
  output logic        frame_start,
  output logic        h_range_err
);

  logic [15:0] v;
  logic [15:0] v_next;
  logic [15:0] v_eff;
  v_state_e    state;
  v_state_e    state_next;
  logic        h_active;
  logic        h_in_sync;
  logic        h_over;
  logic        video_d;

  vga_vertical_counter u_vcnt (
    .clk_25MHz        (clk_25MHz),
    .rst_n            (rst_n),
    .enable_V_Counter (enable_V_Counter),
    .v                (v),
    .v_next           (v_next),
    .state            (state),
    .state_next       (state_next)
  );

  // The counter register already holds v_eff one cycle later, matching output latency.
  assign V_Count_Value = v;

  always_comb begin
    v_eff     = enable_V_Counter ? v_next : v;
    h_active  = H_Count_Value < H_ACTIVE;
    h_in_sync = (H_Count_Value >= H_SYNC_START) && (H_Count_Value <= H_SYNC_END);
    h_over    = H_Count_Value >= H_TOTAL;
    // state_next equals state when no enable, so it is the region of v_eff.
    video_d   = h_active && (state_next == StVAct);
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= !SYNC_POL;
      vsync       <= !SYNC_POL;
      video_on    <= 1'b0;
      pixel_x     <= 10'd0;
      pixel_y     <= 10'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      h_range_err <= 1'b0;
    end else begin
      hsync       <= h_in_sync ? SYNC_POL : !SYNC_POL;
      vsync       <= (state_next == StVSync) ? SYNC_POL : !SYNC_POL;
      video_on    <= video_d;
      pixel_x     <= video_d ? H_Count_Value[9:0] : 10'd0;
      pixel_y     <= video_d ? v_eff[9:0] : 10'd0;
      line_start  <= enable_V_Counter;
      frame_start <= enable_V_Counter && (v_next == 16'd0);
      if (h_over) h_range_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_sync_generator.sv
// Randomized bench for vga_sync_generator against a line-number arithmetic reference model.
module tb_vga_sync_generator;

  localparam logic SYNC_POL = 1'b0;

  logic        clk_25MHz = 1'b0;
  logic        rst_n;
  logic [15:0] H_Count_Value;
  logic        enable_V_Counter;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [15:0] V_Count_Value;
  logic        line_start;
  logic        frame_start;
  logic        h_range_err;

  int n_cmp;
  int n_err;
  int m_v;    // model line number
  bit m_err;  // model sticky range error

  always #20 clk_25MHz = ~clk_25MHz;

  vga_sync_generator #(
    .SYNC_POL (SYNC_POL)
  ) dut (
    .clk_25MHz        (clk_25MHz),
    .rst_n            (rst_n),
    .H_Count_Value    (H_Count_Value),
    .enable_V_Counter (enable_V_Counter),
    .hsync            (hsync),
    .vsync            (vsync),
    .video_on         (video_on),
    .pixel_x          (pixel_x),
    .pixel_y          (pixel_y),
    .V_Count_Value    (V_Count_Value),
    .line_start       (line_start),
    .frame_start      (frame_start),
    .h_range_err      (h_range_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".hsync"}, 32'(hsync), 32'(!SYNC_POL));
    check({tag, ".vsync"}, 32'(vsync), 32'(!SYNC_POL));
    check({tag, ".video_on"}, 32'(video_on), 0);
    check({tag, ".pixel_x"}, 32'(pixel_x), 0);
    check({tag, ".pixel_y"}, 32'(pixel_y), 0);
    check({tag, ".v_count"}, 32'(V_Count_Value), 0);
    check({tag, ".line_start"}, 32'(line_start), 0);
    check({tag, ".frame_start"}, 32'(frame_start), 0);
    check({tag, ".h_range_err"}, 32'(h_range_err), 0);
  endtask

  // Drive one cycle of input, then compare every output against the model.
  task automatic step(input int h, input bit en);
    bit hs;
    bit vid;
    bit vs;
    H_Count_Value    = 16'(h);
    enable_V_Counter = en;
    @(posedge clk_25MHz);
    if (en) m_v = (m_v == 524) ? 0 : m_v + 1;
    if (h >= 800) m_err = 1'b1;
    hs  = (h >= 656) && (h <= 751);
    vs  = (m_v == 490) || (m_v == 491);
    vid = (h < 640) && (m_v < 480);
    #1;
    check("hsync", 32'(hsync), hs ? 32'(SYNC_POL) : 32'(!SYNC_POL));
    check("vsync", 32'(vsync), vs ? 32'(SYNC_POL) : 32'(!SYNC_POL));
    check("video_on", 32'(video_on), 32'(vid));
    check("pixel_x", 32'(pixel_x), vid ? 32'(h) : 0);
    check("pixel_y", 32'(pixel_y), vid ? 32'(m_v) : 0);
    check("v_count", 32'(V_Count_Value), 32'(m_v));
    check("line_start", 32'(line_start), 32'(en));
    check("frame_start", 32'(frame_start), 32'(en && (m_v == 0)));
    check("h_range_err", 32'(h_range_err), 32'(m_err));
  endtask

  // Called just after a rising edge: asserts reset mid-cycle and checks it takes effect at once.
  task automatic reset_mid(input int h, input string tag);
    H_Count_Value    = 16'(h);
    enable_V_Counter = 1'b0;
    #5 rst_n = 1'b0;
    #1 check_reset_values({tag, "_async"});
    m_v   = 0;
    m_err = 1'b0;
    repeat (2) @(posedge clk_25MHz);
    #1 check_reset_values({tag, "_held"});
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
  endtask

  task automatic advance_to(input int target);
    while (m_v != target) step($urandom_range(799, 0), 1'b1);
  endtask

  int n_vid;
  int n_hs;
  int n_fs;
  int n_vs;

  initial begin
    rst_n            = 1'b1;
    H_Count_Value    = 16'd300;
    enable_V_Counter = 1'b0;
    m_v              = 0;
    m_err            = 1'b0;
    repeat (3) @(posedge clk_25MHz);
    #1 reset_mid(300, "rst_h300");

    // Full legal line 0, entered through the 524 -> 0 wrap.
    advance_to(524);
    n_vid = 0; n_hs = 0; n_fs = 0;
    for (int h = 0; h < 800; h++) begin
      step(h, h == 0);
      if (video_on) n_vid++;
      if (hsync == SYNC_POL) n_hs++;
      if (frame_start) n_fs++;
    end
    check("line0_video_cycles", 32'(n_vid), 640);
    check("line0_hsync_cycles", 32'(n_hs), 96);
    check("line0_frame_starts", 32'(n_fs), 1);

    // Whole frame with one enable per cycle.
    n_fs = 0; n_vs = 0;
    for (int i = 0; i < 525; i++) begin
      step($urandom_range(799, 0), 1'b1);
      if (frame_start) n_fs++;
      if (vsync == SYNC_POL) n_vs++;
    end
    check("frame_starts_per_frame", 32'(n_fs), 1);
    check("vsync_lines_per_frame", 32'(n_vs), 2);

    // Random legal traffic with sparse enables.
    for (int i = 0; i < 20000; i++) step($urandom_range(799, 0), ($urandom_range(2, 0) == 0));

    // Active-to-blank boundary: lines 479 and 480 in full.
    advance_to(478);
    for (int h = 0; h < 800; h++) step(h, h == 0);
    n_vid = 0;
    for (int h = 0; h < 800; h++) begin
      step(h, h == 0);
      if (video_on) n_vid++;
    end
    check("line480_video_cycles", 32'(n_vid), 0);

    // Wrap with a new-line pulse at a nonzero H.
    advance_to(524);
    step($urandom_range(799, 1), 1'b1);

    // Out-of-range H: blanked, error sticks through later legal lines.
    step(800 + $urandom_range(1000, 0), 1'b0);
    step(65535, 1'b0);
    for (int h = 0; h < 800; h++) step(h, h == 0);
    for (int i = 0; i < 300; i++) step($urandom_range(799, 0), ($urandom_range(3, 0) == 0));

    // Reset while vsync is active, then one new line.
    advance_to(491);
    for (int h = 1; h < 700; h += 37) step(h, 1'b0);
    reset_mid(0, "rst_vsync");
    step(0, 1'b1);
    for (int h = 1; h < 800; h++) step(h, 1'b0);
    step(0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
